// File: rtl/text_page_renderer.sv
// text_page_renderer
//
// Renders a range of character cells from a text RAM into a pixel framebuffer.
// For each character index in [first_index, last_index] the block reads the
// character code and then each glyph row from the font ROM. It writes one
// colour pixel per cycle.
//
// Optional feature macro: TEXT_RENDER_TRANSPARENT_EN
//   defined   - a latched 'transparent' suppresses writes of background pixels
//   undefined - 'transparent' is ignored and every DRAW cycle writes
//
// Ports
//   clock, resetn             clock, asynchronous active-low reset
//   start                     render request, accepted only when idle
//   first_index, last_index   inclusive character index range
//   fg_color, bg_color        colours for glyph bits 1 / 0
//   transparent               skip background pixels (see macro)
//   busy, done                status; done is a one-cycle pulse
//   text_addr, text_data      text RAM read port (1-cycle latency)
//   font_addr, font_data      font ROM read port {code, row} (1-cycle latency)
//   mem_waddr/wdata/wenable   framebuffer write port
//
// CHAR_W and CHAR_H must be powers of two, each at least 2.
module text_page_renderer #(
  parameter int unsigned COLS     = 80,
  parameter int unsigned ROWS     = 60,
  parameter int unsigned CHAR_W   = 8,
  parameter int unsigned CHAR_H   = 8,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned COLOR_W  = 3,
  parameter int unsigned IDX_W    = 13
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [IDX_W-1:0]             first_index,
  input  logic [IDX_W-1:0]             last_index,
  input  logic [COLOR_W-1:0]           fg_color,
  input  logic [COLOR_W-1:0]           bg_color,
  input  logic                         transparent,
  output logic                         busy,
  output logic                         done,
  output logic [IDX_W-1:0]             text_addr,
  input  logic [7:0]                   text_data,
  output logic [7+$clog2(CHAR_H):0]    font_addr,
  input  logic [CHAR_W-1:0]            font_data,
  output logic [ADDR_W-1:0]            mem_waddr,
  output logic [COLOR_W-1:0]           mem_wdata,
  output logic                         mem_wenable
);

  localparam int unsigned RowW = $clog2(CHAR_H);
  localparam int unsigned PxW  = $clog2(CHAR_W);

  localparam logic [IDX_W-1:0]  MaxIdx   = IDX_W'(COLS * ROWS - 1);
  localparam logic [IDX_W-1:0]  ColsI    = IDX_W'(COLS);
  localparam logic [IDX_W-1:0]  ColLast  = IDX_W'(COLS - 1);
  localparam logic [RowW-1:0]   RowLast  = RowW'(CHAR_H - 1);
  localparam logic [PxW-1:0]    PxLast   = PxW'(CHAR_W - 1);
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(CHAR_H * SCREEN_W);
  localparam logic [ADDR_W-1:0] WrapStep = ADDR_W'(CHAR_H * SCREEN_W - (COLS - 1) * CHAR_W);
  localparam logic [ADDR_W-1:0] CharStep = ADDR_W'(CHAR_W);
  localparam logic [ADDR_W-1:0] LineW    = ADDR_W'(SCREEN_W);

  typedef enum logic [2:0] {
    StIdle, StSeek, StCharReq, StCharWait, StRowReq, StRowWait, StDraw, StDone
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rem_q, rem_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [IDX_W-1:0]     col_q, col_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [COLOR_W-1:0]   fg_q, fg_d;
  logic [COLOR_W-1:0]   bg_q, bg_d;
  logic [7:0]           char_q, char_d;
  logic [RowW-1:0]      glyph_row_q, glyph_row_d;
  logic [CHAR_W-1:0]    row_bits_q, row_bits_d;
  logic [PxW-1:0]       px_q, px_d;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [IDX_W-1:0]     text_addr_q, text_addr_d;
  logic [7+RowW:0]      font_addr_q, font_addr_d;
  logic [ADDR_W-1:0]    mem_waddr_q, mem_waddr_d;
  logic [COLOR_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                 mem_wenable_q, mem_wenable_d;

  logic [IDX_W-1:0]     last_clamped;
  logic                 pix_bit;

`ifdef TEXT_RENDER_TRANSPARENT_EN
  logic                 transp_q, transp_d;
`else
  logic                 unused_transparent;
  assign unused_transparent = transparent;
`endif

  assign last_clamped = (last_index > MaxIdx) ? MaxIdx : last_index;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    base_d      = base_q;
    col_d       = col_q;
    idx_d       = idx_q;
    last_d      = last_q;
    fg_d        = fg_q;
    bg_d        = bg_q;
    char_d      = char_q;
    glyph_row_d = glyph_row_q;
    row_bits_d  = row_bits_q;
    px_d        = px_q;
`ifdef TEXT_RENDER_TRANSPARENT_EN
    transp_d    = transp_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rem_d  = first_index;
          idx_d  = first_index;
          base_d = '0;
          last_d = last_clamped;
          fg_d   = fg_color;
          bg_d   = bg_color;
`ifdef TEXT_RENDER_TRANSPARENT_EN
          transp_d = transparent;
`endif
          state_d = (first_index > last_clamped) ? StDone : StSeek;
        end
      end
      // Repeated subtraction finds the text row; one row step per cycle.
      StSeek: begin
        if (rem_q >= ColsI) begin
          rem_d  = rem_q - ColsI;
          base_d = base_q + LineStep;
        end else begin
          col_d   = rem_q;
          base_d  = base_q + (ADDR_W'(rem_q) << PxW);
          state_d = StCharReq;
        end
      end
      StCharReq: state_d = StCharWait;
      StCharWait: begin
        char_d      = text_data;
        glyph_row_d = '0;
        state_d     = StRowReq;
      end
      StRowReq: state_d = StRowWait;
      StRowWait: begin
        row_bits_d = font_data;
        px_d       = '0;
        state_d    = StDraw;
      end
      StDraw: begin
        if (px_q != PxLast) begin
          px_d = px_q + PxW'(1);
        end else if (glyph_row_q != RowLast) begin
          glyph_row_d = glyph_row_q + RowW'(1);
          state_d     = StRowReq;
        end else if (idx_q == last_q) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (col_q == ColLast) begin
            col_d  = '0;
            base_d = base_q + WrapStep;
          end else begin
            col_d  = col_q + IDX_W'(1);
            base_d = base_q + CharStep;
          end
          state_d = StCharReq;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered from next-state values so they line up with the
    // state they belong to.
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    text_addr_d = (state_d == StCharReq) ? idx_d : text_addr_q;
    font_addr_d = (state_d == StRowReq) ? {char_d, glyph_row_d} : font_addr_q;

    // MSB is leftmost, and CHAR_W is a power of two, so bit CHAR_W-1-px is ~px.
    pix_bit       = row_bits_d[~px_d];
    mem_waddr_d   = mem_waddr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wenable_d = 1'b0;
    if (state_d == StDraw) begin
      mem_waddr_d = base_d + ADDR_W'(glyph_row_d) * LineW + ADDR_W'(px_d);
      mem_wdata_d = pix_bit ? fg_d : bg_d;
`ifdef TEXT_RENDER_TRANSPARENT_EN
      mem_wenable_d = pix_bit | ~transp_d;
`else
      mem_wenable_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      rem_q         <= '0;
      base_q        <= '0;
      col_q         <= '0;
      idx_q         <= '0;
      last_q        <= '0;
      fg_q          <= '0;
      bg_q          <= '0;
      char_q        <= '0;
      glyph_row_q   <= '0;
      row_bits_q    <= '0;
      px_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      text_addr_q   <= '0;
      font_addr_q   <= '0;
      mem_waddr_q   <= '0;
      mem_wdata_q   <= '0;
      mem_wenable_q <= 1'b0;
`ifdef TEXT_RENDER_TRANSPARENT_EN
      transp_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      base_q        <= base_d;
      col_q         <= col_d;
      idx_q         <= idx_d;
      last_q        <= last_d;
      fg_q          <= fg_d;
      bg_q          <= bg_d;
      char_q        <= char_d;
      glyph_row_q   <= glyph_row_d;
      row_bits_q    <= row_bits_d;
      px_q          <= px_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      text_addr_q   <= text_addr_d;
      font_addr_q   <= font_addr_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wenable_q <= mem_wenable_d;
`ifdef TEXT_RENDER_TRANSPARENT_EN
      transp_q      <= transp_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign text_addr   = text_addr_q;
  assign font_addr   = font_addr_q;
  assign mem_waddr   = mem_waddr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wenable = mem_wenable_q;

endmodule

// File: tb/tb_text_page_renderer.sv
// Directed, table-driven bench for text_page_renderer at default geometry
// (80x60 cells, 8x8 glyphs, 640-pixel lines).
module tb_text_page_renderer;

`ifdef TEXT_RENDER_TRANSPARENT_EN
  localparam bit TranspOn = 1'b1;
`else
  localparam bit TranspOn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [12:0] first_index = '0;
  logic [12:0] last_index = '0;
  logic [2:0]  fg_color = '0;
  logic [2:0]  bg_color = '0;
  logic        transparent = 1'b0;
  logic        busy, done;
  logic [12:0] text_addr;
  logic [7:0]  text_data = '0;
  logic [10:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [18:0] mem_waddr;
  logic [2:0]  mem_wdata;
  logic        mem_wenable;

  int checks = 0;
  int failures = 0;
  int font_mode = 0;
  logic [7:0] tram [8192];

  text_page_renderer dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .first_index (first_index),
    .last_index  (last_index),
    .fg_color    (fg_color),
    .bg_color    (bg_color),
    .transparent (transparent),
    .busy        (busy),
    .done        (done),
    .text_addr   (text_addr),
    .text_data   (text_data),
    .font_addr   (font_addr),
    .font_data   (font_data),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_wenable (mem_wenable)
  );

  always #5 clock = ~clock;

  // Font patterns: 0 diagonal, 1 blank, 2 code-dependent.
  function automatic logic [7:0] font_row(input logic [7:0] code, input logic [2:0] r);
    if (font_mode == 0) return 8'h80 >> r;
    if (font_mode == 1) return 8'h00;
    return code ^ {1'b0, r, 1'b0, r};
  endfunction

  always @(posedge clock) begin
    text_data <= tram[text_addr];
    font_data <= font_row(font_addr[10:3], font_addr[2:0]);
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int          first;
    int          last;
    logic [2:0]  fg;
    logic [2:0]  bg;
    logic        transp;
    int          mode;
    int          n_writes;
    int          a_first;
    int          a_last;
    int          done_k;   // cycles from accepting edge to done
    int          text_k;   // cycles to first text_addr, 0 = not checked
  } vec_t;

  // Runs one render; poke_k > 0 pulses a second start at that cycle with
  // different inputs, which must have no effect.
  task automatic run_vec(input vec_t v, input int vi, input int poke_k);
    int exp_a[$];
    int exp_d[$];
    int got_a[$];
    int got_d[$];
    int done_k = -1;
    int text_k = -1;
    int busy1 = 0;
    int errs = 0;
    int lastc;
    logic [7:0] bits;
    logic en_t;

    font_mode = v.mode;
    en_t = TranspOn & v.transp;
    lastc = (v.last > 4799) ? 4799 : v.last;
    for (int idx = v.first; idx <= lastc; idx++) begin
      for (int r = 0; r < 8; r++) begin
        bits = font_row(tram[idx], 3'(r));
        for (int c = 0; c < 8; c++) begin
          if (bits[7-c] || !en_t) begin
            exp_a.push_back((idx / 80) * 5120 + (idx % 80) * 8 + r * 640 + c);
            exp_d.push_back(bits[7-c] ? int'(v.fg) : int'(v.bg));
          end
        end
      end
    end

    @(negedge clock);
    first_index = 13'(v.first);
    last_index  = 13'(v.last);
    fg_color    = v.fg;
    bg_color    = v.bg;
    transparent = v.transp;
    start       = 1'b1;
    for (int k = 1; k <= 3000 && done_k < 0; k++) begin
      @(negedge clock);
      if (k == poke_k) begin
        start = 1'b1;
        first_index = 13'd100;
        last_index  = 13'd100;
        fg_color    = 3'd1;
        bg_color    = 3'd3;
        transparent = ~v.transp;
      end else begin
        start = 1'b0;
      end
      if (k == 1) busy1 = int'(busy);
      if (mem_wenable) begin
        got_a.push_back(int'(mem_waddr));
        got_d.push_back(int'(mem_wdata));
      end
      if (text_k < 0 && int'(text_addr) == v.first) text_k = k;
      if (done) done_k = k;
    end
    start = 1'b0;
    check($sformatf("v%0d done_latency", vi), done_k, v.done_k);
    check($sformatf("v%0d busy_after_start", vi), busy1, 1);
    @(negedge clock);
    check($sformatf("v%0d idle_after_done", vi), {done, busy}, 0);
    check($sformatf("v%0d write_count", vi), got_a.size(), v.n_writes);
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
      if (got_a[i] != exp_a[i] || got_d[i] != exp_d[i]) errs++;
    check($sformatf("v%0d stream_errors", vi), errs + (got_a.size() != exp_a.size()), 0);
    if (v.n_writes > 0 && got_a.size() > 0) begin
      check($sformatf("v%0d first_addr", vi), got_a[0], v.a_first);
      check($sformatf("v%0d last_addr", vi), got_a[got_a.size()-1], v.a_last);
    end
    if (v.text_k > 0) check($sformatf("v%0d text_latency", vi), text_k, v.text_k);
  endtask

  vec_t vecs[7];
  int   seen;

  initial begin
    for (int i = 0; i < 8192; i++) tram[i] = 8'(i) ^ 8'h41;

    //        first last  fg    bg    tr  mode n_wr a_first a_last done_k text_k
    vecs[0] = '{4799, 4799, 3'd3, 3'd4, 1'b0, 0, 64, 302712, 307199, 143, 61};
    vecs[1] = '{0,    0,    3'd7, 3'd0, 1'b0, 0, 64, 0,      4487,   84,  2};
    vecs[2] = '{79,   80,   3'd5, 3'd2, 1'b0, 0, 128, 632,   9607,   166, 2};
    vecs[3] = '{10,   5,    3'd7, 3'd0, 1'b0, 0, 0,  0,      0,      1,   0};
    vecs[4] = '{4798, 8000, 3'd2, 3'd5, 1'b0, 0, 128, 302704, 307199, 225, 61};
    vecs[5] = '{3,    3,    3'd6, 3'd1, 1'b1, 1, TranspOn ? 0 : 64, 24, 4511, 84, 2};
    vecs[6] = '{160,  161,  3'd1, 3'd6, 1'b0, 2, 128, 10240, 14735,  168, 4};

    // Reset state
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst text_addr", text_addr, 0);
    check("rst font_addr", font_addr, 0);
    check("rst mem_waddr", mem_waddr, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst mem_wenable", mem_wenable, 0);
    #20;
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i, 0);

    // Start pulse while busy must be ignored
    run_vec(vecs[1], 7, 10);

    // Reset asserted mid-DRAW aborts with outputs cleared and no done pulse
    font_mode = 0;
    @(negedge clock);
    first_index = 13'd85;
    last_index  = 13'd85;
    fg_color    = 3'd7;
    bg_color    = 3'd0;
    transparent = 1'b0;
    start       = 1'b1;
    seen = 0;
    for (int k = 0; k < 300 && seen == 0; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (mem_wenable && mem_waddr == 19'd5801) seen = 1;
    end
    check("abort reached_draw", seen, 1);
    resetn = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort text_addr", text_addr, 0);
    check("abort font_addr", font_addr, 0);
    check("abort mem_waddr", mem_waddr, 0);
    check("abort mem_wdata", mem_wdata, 0);
    check("abort mem_wenable", mem_wenable, 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    seen = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clock);
      if (done || busy || mem_wenable) seen++;
    end
    check("abort no_activity_after", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
